// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter.
//   ptr_next      : advance a requester index by one with an explicit wrap at
//                   the requester count (no power-of-two assumption).
//   onehot_to_idx : OR-encode a one-hot vector into its binary index. There
//                   is no priority chain, so the input must be one-hot or zero.
// MAX_WIDTH bounds the vector width accepted by onehot_to_idx. Arbiter WIDTH
// must not exceed it.
package rr_arbiter_pkg;

    localparam int MAX_WIDTH = 256;

    function automatic logic [31:0] ptr_next(input logic [31:0] k,
                                             input logic [31:0] width);
        return (k + 32'd1 == width) ? 32'd0 : k + 32'd1;
    endfunction

    function automatic logic [31:0] onehot_to_idx(input logic [MAX_WIDTH-1:0] onehot);
        logic [31:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (onehot[i]) idx = idx | 32'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_select.sv
// Combinational round-robin winner selection.
// Ports:
//   req       : request levels, WIDTH bits
//   ptr       : index of the highest-priority requester
//   grant     : one-hot winner (all-zero when req is zero)
//   grant_idx : binary index of the winner
// The selection is a masked double scan. Requests at or above ptr are tried
// first. If none of them is set, the lowest set request overall wins, which
// is the wrap-around half of the scan.
module rr_arbiter_select
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int WIDTH_LOG = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]     req,
    input  logic [WIDTH_LOG-1:0] ptr,
    output logic [WIDTH-1:0]     grant,
    output logic [WIDTH_LOG-1:0] grant_idx
);

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] masked;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path, so no latch is inferred.
        mask      = '0;
        masked    = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked = req & mask;
        // x & -x isolates the lowest set bit, so the result is always one-hot
        // or zero.
        grant     = (|masked) ? (masked & -masked) : (req & -req);
        grant_idx = WIDTH_LOG'(onehot_to_idx(MAX_WIDTH'(grant)));
    end

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Registered round-robin arbiter feeding the one-hot encoder stage.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   req        : per-requester request levels
//   req_ack    : one-hot pulse, the requester is consumed this cycle
//   out_vld    : output register holds a grant
//   out_rdy    : consumer accepts the grant
//   out_onehot : granted requester, one-hot, zero when out_vld is low
//   out_idx    : binary grant index (only with RR_ARBITER_ONEHOT_IDX_EN)
// Macro RR_ARBITER_ONEHOT_IDX_EN adds the out_idx port and its register.
// out_onehot comes only from flops. out_rdy reaches req_ack through the
// load condition, but it never reaches the output vector.
module rr_arbiter_onehot
    import rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int WIDTH_LOG = (WIDTH == 1) ? 1 : $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    output logic [WIDTH-1:0]     req_ack,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [WIDTH-1:0]     out_onehot
`ifdef RR_ARBITER_ONEHOT_IDX_EN
    ,
    output logic [WIDTH_LOG-1:0] out_idx
`endif
);

    logic [WIDTH_LOG-1:0] ptr;
    logic [WIDTH-1:0]     winner;
    logic [WIDTH_LOG-1:0] winner_idx;
    logic                 load;

    rr_arbiter_select #(
        .WIDTH     (WIDTH),
        .WIDTH_LOG (WIDTH_LOG)
    ) u_select (
        .req       (req),
        .ptr       (ptr),
        .grant     (winner),
        .grant_idx (winner_idx)
    );

    // A stalled register does not sample requests. An empty or draining
    // register takes a new winner on the same edge.
    assign load = (|req) & (~out_vld | out_rdy);

    // The ack is gated by rst_n so that no requester sees itself consumed
    // while the register is held in reset.
    assign req_ack = (load & rst_n) ? winner : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        // All state is reset, including ptr, so requester 0 has top priority
        // after reset.
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_onehot <= '0;
            ptr        <= '0;
        end else if (load) begin
            out_vld    <= 1'b1;
            out_onehot <= winner;
            ptr        <= WIDTH_LOG'(ptr_next(32'(winner_idx), 32'(WIDTH)));
        end else if (out_vld & out_rdy) begin
            out_vld    <= 1'b0;
            out_onehot <= '0;
        end
    end

`ifdef RR_ARBITER_ONEHOT_IDX_EN
    // The index register follows exactly the same update rules as out_onehot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx <= '0;
        end else if (load) begin
            out_idx <= winner_idx;
        end else if (out_vld & out_rdy) begin
            out_idx <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_rr_arbiter_onehot.sv
// Self-checking bench for rr_arbiter_onehot: a WIDTH=4 instance is driven
// from a vector table with a scoreboard queue, and a WIDTH=5 instance covers
// a non-power-of-two pointer wrap.
module tb_rr_arbiter_onehot;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] req_ack;
    logic       out_vld;
    logic       out_rdy;
    logic [3:0] out_onehot;
    logic [1:0] out_idx;

    logic [4:0] req5;
    logic [4:0] req_ack5;
    logic       out_vld5;
    logic       out_rdy5;
    logic [4:0] out_onehot5;
    logic [2:0] out_idx5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_onehot #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_ack    (req_ack),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_onehot (out_onehot)
`ifdef RR_ARBITER_ONEHOT_IDX_EN
        ,
        .out_idx    (out_idx)
`endif
    );

    rr_arbiter_onehot #(.WIDTH(5)) dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req5),
        .req_ack    (req_ack5),
        .out_vld    (out_vld5),
        .out_rdy    (out_rdy5),
        .out_onehot (out_onehot5)
`ifdef RR_ARBITER_ONEHOT_IDX_EN
        ,
        .out_idx    (out_idx5)
`endif
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] ack;
        logic       vld;
        logic [3:0] oh;
        logic [1:0] idx;
    } vec_t;

    typedef struct {
        logic       vld;
        logic [3:0] oh;
        logic [1:0] idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    // Drive one cycle on the WIDTH=4 instance: check the combinational ack
    // before the edge and the registered result after it.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        req     = v.req;
        out_rdy = v.rdy;
        #1;
        check({tag, ".req_ack"}, 32'(req_ack), 32'(v.ack));
        sb.push_back('{v.vld, v.oh, v.idx});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".out_vld"}, 32'(out_vld), 32'(e.vld));
            check({tag, ".out_onehot"}, 32'(out_onehot), 32'(e.oh));
`ifdef RR_ARBITER_ONEHOT_IDX_EN
            check({tag, ".out_idx"}, 32'(out_idx), 32'(e.idx));
`endif
        end
    endtask

    task automatic apply5(input string tag, input logic [4:0] r,
                          input logic [4:0] exp_ack, input logic exp_vld,
                          input logic [4:0] exp_oh);
        @(negedge clk);
        req5     = r;
        out_rdy5 = 1'b1;
        #1;
        check({tag, ".req_ack"}, 32'(req_ack5), 32'(exp_ack));
        @(posedge clk);
        #1;
        check({tag, ".out_vld"}, 32'(out_vld5), 32'(exp_vld));
        check({tag, ".out_onehot"}, 32'(out_onehot5), 32'(exp_oh));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Fields: req, rdy, req_ack, out_vld, out_onehot, out_idx after edge
        // fairness with all four requesting, starting from ptr=0
        vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2});
        vecs.push_back('{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0});
        // drain, ptr stays 1
        vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0});
        vecs.push_back('{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1});
        // backpressure: grant 0010 held, ptr=2
        vecs.push_back('{4'b1101, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1101, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1101, 1'b0, 4'b0000, 1'b1, 4'b0010, 2'd1});
        vecs.push_back('{4'b1101, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2});
        // wrap from ptr=3
        vecs.push_back('{4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{4'b0011, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1});
        // only request is below ptr=2
        vecs.push_back('{4'b0001, 1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0});
        // stall with no request, then drain
        vecs.push_back('{4'b0000, 1'b0, 4'b0000, 1'b1, 4'b0001, 2'd0});
        vecs.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0});
        // load into an empty register while out_rdy=0 (ptr=1)
        vecs.push_back('{4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{4'b0100, 1'b0, 4'b0000, 1'b1, 4'b1000, 2'd3});
        vecs.push_back('{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2});

        req      = 4'b1111;
        out_rdy  = 1'b1;
        req5     = '0;
        out_rdy5 = 1'b1;
        rst_n    = 1'b0;
        #2;
        check("reset.out_vld", 32'(out_vld), 32'd0);
        check("reset.out_onehot", 32'(out_onehot), 32'd0);
        check("reset.req_ack", 32'(req_ack), 32'd0);
`ifdef RR_ARBITER_ONEHOT_IDX_EN
        check("reset.out_idx", 32'(out_idx), 32'd0);
`endif
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while a grant is held (out_vld=1, ptr=3): drops at once.
        @(negedge clk);
        req   = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("midrst.out_vld", 32'(out_vld), 32'd0);
        check("midrst.out_onehot", 32'(out_onehot), 32'd0);
        check("midrst.req_ack", 32'(req_ack), 32'd0);
`ifdef RR_ARBITER_ONEHOT_IDX_EN
        check("midrst.out_idx", 32'(out_idx), 32'd0);
`endif
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        // ptr back at 0: bit 1 beats bit 3 (ptr=3 would have picked bit 3)
        apply("postrst0", '{4'b1010, 1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1});
        apply("postrst1", '{4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3});
        apply("postrst2", '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0});

        // WIDTH=5: move ptr to 4, grant bit 4, then ptr wraps to 0.
        apply5("w5_a", 5'b01000, 5'b01000, 1'b1, 5'b01000);
        apply5("w5_b", 5'b10000, 5'b10000, 1'b1, 5'b10000);
        apply5("w5_c", 5'b11111, 5'b00001, 1'b1, 5'b00001);
        apply5("w5_d", 5'b00000, 5'b00000, 1'b0, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_onehot.md
# rr_arbiter_onehot

Registered round-robin arbiter that sits directly upstream of the one-hot encoder stage. It picks one of WIDTH level-sensitive requesters per transfer and holds the winner in a single-entry output register with a valid/ready handshake. The winner is presented as a one-hot vector, and optionally as a binary index. Downstream logic relies on `out_onehot` being strictly one-hot (or all-zero) to use OR-based encoding without a priority chain.

## Interface
- `WIDTH`, default 32: number of requesters, ≥1, not required to be a power of two.
- `WIDTH_LOG` (localparam): `$clog2(WIDTH)`, forced to 1 when WIDTH=1.
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `req`, input, WIDTH: per-requester request level.
- `req_ack`, output, WIDTH: one-hot single-cycle pulse; the requester was selected this cycle.
- `out_vld`, output, 1: output register holds a grant.
- `out_rdy`, input, 1: consumer accepts the grant.
- `out_onehot`, output, WIDTH: granted requester, one-hot; all-zero when `out_vld`=0.
- `out_idx`, output, WIDTH_LOG: binary index of the grant (present only with the macro, see Configuration).

## Operation
- State:
  - output register: `out_vld`, `out_onehot`, `out_idx`.
  - priority pointer `ptr` in [0, WIDTH-1].
- Load condition: `load = (|req) & (~out_vld | out_rdy)`.
- Selection:
  - Scan `req` starting at `ptr`, ascending, wrapping from WIDTH-1 to 0.
  - The first set bit k wins. Exactly one winner whenever `|req`.
- On load:
  - `out_onehot <= 1<<k`, `out_vld <= 1`, `out_idx <= k`.
  - `req_ack[k] = 1` in the same cycle (combinational).
  - `ptr <= (k+1 == WIDTH) ? 0 : k+1`. Wrap is explicit; no modulo-2^n arithmetic.
- Acknowledgement contract: the requester treats `req_ack` as consumption of its request. It drops `req` the following cycle unless it has another request.
- Transfer without load (`out_vld & out_rdy & ~|req`):
  - `out_vld <= 0`, `out_onehot <= 0`, `out_idx <= 0`.
  - `ptr` unchanged.
- Stall (`out_vld & ~out_rdy`):
  - Output register and `ptr` hold.
  - `req_ack = 0`. Requests are not sampled.
- Simultaneous transfer and load: the new grant replaces the old one in the same edge, so throughput is one grant per cycle.
- Invariant: `out_onehot` is zero or one-hot at all times; `req_ack` is zero or one-hot.
- WIDTH=1: `ptr` is constant 0 and the arbiter degenerates to a one-entry register stage.

## Timing
- Reset (async, `rst_n`=0): `out_vld`=0, `out_onehot`=0, `out_idx`=0, `ptr`=0 (requester 0 highest priority).
- `req_ack` is combinational. It is 0 during reset and whenever `out_vld & ~out_rdy`.
- Latency: `req` sampled at edge N, so `out_vld`/`out_onehot` are valid after edge N. One cycle.
- `req_ack` asserts in the sampling cycle, before the edge.
- No combinational path from `out_rdy` to `out_onehot`. There is a path from `out_rdy` to `req_ack`.
- Reset mid-operation: any pending grant is dropped without transfer. The requester already acked does not get a retry; system-level reset covers it.
- Deassertion of `rst_n` is synchronised externally; the block assumes a clean release.

## Configuration
- `RR_ARBITER_ONEHOT_IDX_EN`
  - Defined: the `out_idx` port and its register exist. The index is encoded from the winner with OR-reduction (no priority logic) and registered together with `out_onehot`.
  - Undefined: no `out_idx` port and no index register. The consumer encodes `out_onehot` itself. All other behaviour is identical.

## Structure
- Shared package `rr_arbiter_pkg`:
  - pointer-increment-with-wrap function, parameterised by WIDTH.
  - `onehot_to_idx` OR-encoding function.
- Sub-module `rr_arbiter_select` (combinational):
  - Inputs: `req`, `ptr`. Outputs: one-hot winner, winner index.
  - Implemented as a masked double priority scan: requests at or above `ptr` first, then all requests.
- Top level holds the output register, pointer register and handshake logic.

## Test plan
All scenarios use WIDTH=4 unless noted, with the macro defined.
- Reset: `rst_n`=0 mid-stream with `out_vld`=1 → `out_vld`=0, `out_onehot`=4'b0000, `out_idx`=0 immediately. After release, `req`=4'b1000 → grant 4'b1000 (`ptr` was reset to 0).
- Fairness: `req`=4'b1111 held (bench re-asserts after ack), `out_rdy`=1 → `out_onehot` sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, `req_ack` matching one cycle earlier.
- Backpressure: grant 4'b0010 held, `out_rdy`=0 for 3 cycles, `req`=4'b1101 → `out_onehot` stable, `req_ack`=0, `ptr`=2. On `out_rdy`=1 → next grant 4'b0100.
- Wrap: `ptr`=3, `req`=4'b0011 → grant 4'b0001, `out_idx`=0, `ptr`=1.
- Drain: `out_vld`=1, `out_rdy`=1, `req`=0 → next cycle `out_vld`=0, `out_onehot`=0, `ptr` unchanged.
- WIDTH=5, macro undefined: `req`=5'b10000 from `ptr`=4 → grant 5'b10000, `ptr` wraps to 0. Elaboration has no `out_idx` port.
